// File: rtl/vram_slot_arbiter.sv
// Time-slotted VRAM controller: NBANK banks of byte-laned block RAM shared by one
// CPU slot and one or two graphics fetch slots per 24-clock window.
module vram_slot_arbiter #(
  parameter int AW       = 12,
  parameter int DW       = 16,
  parameter int NBANK    = 2,
  parameter int GFX_MODE = 0,
  localparam int BL      = DW / 8
) (
  input  logic                i_EMU_MCLK,
  input  logic                i_EMU_RST,
  input  logic [4:0]          i_EMU_TIMING,
  input  logic [NBANK-1:0]    i_CS_n,
  input  logic [AW-1:0]       i_CPUADDR,
  input  logic [DW-1:0]       i_CPUWDATA,
  input  logic                i_CPURW,
  input  logic [BL-1:0]       i_CPUBE_n,
  output logic [DW-1:0]       o_CPURDATA,
  output logic                o_CPUACK,
  input  logic [AW-1:0]       i_GFXADDR_A,
  input  logic [AW-1:0]       i_GFXADDR_B,
  output logic [NBANK*DW-1:0] o_GFXDATA_A,
  output logic [NBANK*DW-1:0] o_GFXDATA_B,
  output logic                o_GFXVALID_A,
  output logic                o_GFXVALID_B
);

  logic [1:0] pix;
  logic [2:0] ph;
  assign pix = i_EMU_TIMING[4:3];
  assign ph  = i_EMU_TIMING[2:0];

  // Slot strobes; phases 6/7 never match so illegal codes fall through as no-ops.
  logic slot_latch, slot_cpu, slot_ack, slot_ga, slot_gav, slot_gb, slot_gbv;
  assign slot_latch = (pix == 2'd0) && (ph == 3'd0);
  assign slot_cpu   = (pix == 2'd0) && (ph == 3'd2);
  assign slot_ack   = (pix == 2'd0) && (ph == 3'd4);
  assign slot_ga    = (pix == 2'd2) && (ph == 3'd2);
  assign slot_gav   = (pix == 2'd2) && (ph == 3'd4);
  assign slot_gb    = (GFX_MODE != 0) && (pix == 2'd3) && (ph == 3'd2);
  assign slot_gbv   = (GFX_MODE != 0) && (pix == 2'd3) && (ph == 3'd4);

  logic             pending, cpu_go, rw_q;
  logic [NBANK-1:0] cs_q;
  logic [AW-1:0]    addr_q;
  logic [BL-1:0]    be_q;
  logic [1:0]       sel_q, sel_d;

  logic cpu_hit;
  assign cpu_hit = slot_cpu && pending && (cs_q == i_CS_n);

  logic rd_en;
  assign rd_en = cpu_hit || slot_ga || slot_gb;

  logic [AW-1:0] rd_addr;
  always_comb begin
    rd_addr = addr_q;
    if (slot_ga)      rd_addr = i_GFXADDR_A;
    else if (slot_gb) rd_addr = i_GFXADDR_B;
  end

  // Reads with several chip selects low return the lowest-index bank.
  always_comb begin
    sel_d = 2'd0;
    for (int b = NBANK - 1; b >= 0; b--)
      if (!i_CS_n[b]) sel_d = 2'(b);
  end

  logic [NBANK*DW-1:0] rd_flat;

  for (genvar g = 0; g < NBANK; g++) begin : g_bank
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] q;
    logic          we;
    assign we = cpu_hit && !rw_q && !cs_q[g];
    always_ff @(posedge i_EMU_MCLK) begin
      if (we)
        for (int l = 0; l < BL; l++)
          if (!be_q[l]) mem[addr_q][l*8 +: 8] <= i_CPUWDATA[l*8 +: 8];
      if (rd_en) q <= mem[rd_addr];
    end
    assign rd_flat[g*DW +: DW] = q;
  end

  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_RST) begin
    if (i_EMU_RST) begin
      pending    <= 1'b0;
      cpu_go     <= 1'b0;
      rw_q       <= 1'b1;
      cs_q       <= '1;
      addr_q     <= '0;
      be_q       <= '1;
      sel_q      <= 2'd0;
      o_CPURDATA <= '1;
      o_CPUACK   <= 1'b0;
    end else begin
      o_CPUACK <= 1'b0;
      if (slot_latch) begin
        cpu_go <= 1'b0;
        if (i_CS_n != '1) begin
          pending <= 1'b1;
          cs_q    <= i_CS_n;
          addr_q  <= i_CPUADDR;
          rw_q    <= i_CPURW;
          be_q    <= i_CPUBE_n;
          sel_q   <= sel_d;
        end else begin
          pending <= 1'b0;
        end
      end
      // A chip select that moved since the latch abandons the access silently.
      if (slot_cpu && pending) begin
        if (cs_q == i_CS_n) cpu_go  <= 1'b1;
        else                pending <= 1'b0;
      end
      if (slot_ack) begin
        pending <= 1'b0;
        cpu_go  <= 1'b0;
        if (cpu_go) begin
          o_CPUACK <= 1'b1;
          if (rw_q) o_CPURDATA <= rd_flat[32'(sel_q)*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_RST) begin
    if (i_EMU_RST) begin
      o_GFXDATA_A  <= '1;
      o_GFXVALID_A <= 1'b0;
    end else begin
      o_GFXVALID_A <= slot_gav;
      if (slot_gav) o_GFXDATA_A <= rd_flat;
    end
  end

  if (GFX_MODE != 0) begin : g_slot_b
    always_ff @(posedge i_EMU_MCLK or posedge i_EMU_RST) begin
      if (i_EMU_RST) begin
        o_GFXDATA_B  <= '1;
        o_GFXVALID_B <= 1'b0;
      end else begin
        o_GFXVALID_B <= slot_gbv;
        if (slot_gbv) o_GFXDATA_B <= rd_flat;
      end
    end
  end else begin : g_no_slot_b
    assign o_GFXDATA_B  = '1;
    assign o_GFXVALID_B = 1'b0;
  end

endmodule
